// File: rtl/operand_ctrl.sv
// operand_ctrl: debounced pushbutton front end that steps two operands and an
// ALU op select, and on a commit press latches them for the ALU.
//   CLOCK_50      clock (rising edge)
//   RESET_N       asynchronous active-low reset
//   KEY[3:0]      raw active-low buttons: [0] op, [1] B, [2] A, [3] commit
//   SW            step direction (0 = up, 1 = down)
//   A, B, OP      live operand / op values
//   A_Q,B_Q,OP_Q  committed values
//   VALID         one-cycle pulse when the committed values load
module operand_ctrl #(
    parameter int unsigned WIDTH        = 8,
    parameter int unsigned MAX_VAL      = 9,
    parameter int unsigned NOPS         = 4,
    parameter int unsigned DEBOUNCE_CYC = 500000
) (
    input  logic             CLOCK_50,
    input  logic             RESET_N,
    input  logic [3:0]       KEY,
    input  logic             SW,
    output logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] B,
    output logic [3:0]       OP,
    output logic [WIDTH-1:0] A_Q,
    output logic [WIDTH-1:0] B_Q,
    output logic [3:0]       OP_Q,
    output logic             VALID
);

    localparam int unsigned      CNT_W  = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [WIDTH-1:0] MAX_V  = WIDTH'(MAX_VAL);
    localparam logic [3:0]       MAX_OP = 4'(NOPS - 1);

    logic [3:0]       key_s1;
    logic [3:0]       key_s2;
    logic [3:0]       stable;
    logic [3:0]       stable_d;
    logic [CNT_W-1:0] cnt [4];
    logic             sw_s1;
    logic             sw_s2;
    logic [3:0]       press_c;

    // Wrap-around step for an operand bounded by MAX_V.
    function automatic logic [WIDTH-1:0] step_val(input logic [WIDTH-1:0] v,
                                                  input logic down);
        if (down) begin
            return (v == '0) ? MAX_V : v - WIDTH'(1);
        end
        return (v == MAX_V) ? '0 : v + WIDTH'(1);
    endfunction

    // Wrap-around step for the op select bounded by NOPS-1.
    function automatic logic [3:0] step_op(input logic [3:0] v, input logic down);
        if (down) begin
            return (v == '0) ? MAX_OP : v - 4'(1);
        end
        return (v == MAX_OP) ? '0 : v + 4'(1);
    endfunction

    // Synchronizers and per-key debounce: the stable state flips only after the
    // synchronized value has disagreed with it for DEBOUNCE_CYC straight cycles.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            key_s1   <= '1;
            key_s2   <= '1;
            stable   <= '1;
            stable_d <= '1;
            sw_s1    <= 1'b0;
            sw_s2    <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            key_s1   <= KEY;
            key_s2   <= key_s1;
            stable_d <= stable;
            sw_s1    <= SW;
            sw_s2    <= sw_s1;
            for (int i = 0; i < 4; i++) begin
                if (key_s2[i] != stable[i]) begin
                    if (cnt[i] == CNT_W'(DEBOUNCE_CYC)) begin
                        stable[i] <= key_s2[i];
                        cnt[i]    <= '0;
                    end else begin
                        cnt[i] <= cnt[i] + CNT_W'(1);
                    end
                end else begin
                    cnt[i] <= '0;
                end
            end
        end
    end

    // Press event: the cycle right after a stable 1->0 transition.
    assign press_c = stable_d & ~stable;

    // Operand stepping and commit; commit captures the pre-step values.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            A     <= '0;
            B     <= '0;
            OP    <= '0;
            A_Q   <= '0;
            B_Q   <= '0;
            OP_Q  <= '0;
            VALID <= 1'b0;
        end else begin
            if (press_c[2]) begin
                A <= step_val(A, sw_s2);
            end
            if (press_c[1]) begin
                B <= step_val(B, sw_s2);
            end
            if (press_c[0]) begin
                OP <= step_op(OP, sw_s2);
            end
            if (press_c[3]) begin
                A_Q  <= A;
                B_Q  <= B;
                OP_Q <= OP;
            end
            VALID <= press_c[3];
        end
    end

endmodule
